// File: rtl/disp_channel_scan_pkg.sv
// Shared constants for the channel-scan display: segment codes, FSM states, decoder modes.
package disp_channel_scan_pkg;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic {
        SHOW_ID,
        SHOW_VAL
    } state_e;

    typedef enum logic [1:0] {
        MODE_DIGIT,
        MODE_C,
        MODE_BLANK
    } seg_mode_e;

endpackage

// File: rtl/disp_channel_scan_if.sv
// Channel bus in, seven-segment pins out. The design side uses the slave modport.
interface disp_channel_scan_if #(
    parameter int unsigned N_CH = 13
);
    logic [16*N_CH-1:0] channels_bcd;
    logic               hold;
    logic               next_ch;
    logic [3:0]         ch_idx;
    logic [3:0]         an;
    logic [6:0]         seg;
    logic               dp;

    modport master (
        output channels_bcd, hold, next_ch,
        input  ch_idx, an, seg, dp
    );

    modport slave (
        input  channels_bcd, hold, next_ch,
        output ch_idx, an, seg, dp
    );
endinterface

// File: rtl/disp_channel_scan_seg7_decoder.sv
// Combinational {mode, nibble} -> active-low seven-segment pattern.
module seg7_decoder
    import disp_channel_scan_pkg::*;
(
    input  seg_mode_e   mode_i,
    input  logic [3:0]  nibble_i,
    output logic [6:0]  seg_o
);

    // Digits 0-9 decode normally; any non-BCD nibble renders as a dash
    always_comb begin
        seg_o = SEG_BLANK;
        unique case (mode_i)
            MODE_DIGIT: begin
                case (nibble_i)
                    4'd0:    seg_o = SEG_0;
                    4'd1:    seg_o = SEG_1;
                    4'd2:    seg_o = SEG_2;
                    4'd3:    seg_o = SEG_3;
                    4'd4:    seg_o = SEG_4;
                    4'd5:    seg_o = SEG_5;
                    4'd6:    seg_o = SEG_6;
                    4'd7:    seg_o = SEG_7;
                    4'd8:    seg_o = SEG_8;
                    4'd9:    seg_o = SEG_9;
                    default: seg_o = SEG_DASH;
                endcase
            end
            MODE_C:     seg_o = SEG_C;
            MODE_BLANK: seg_o = SEG_BLANK;
            default:    seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/disp_channel_scan.sv
// Rotating channel display: "C nn" ID frame, then the channel value X.XXX, per channel.
module disp_channel_scan
    import disp_channel_scan_pkg::*;
#(
    parameter int unsigned N_CH       = 13,
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned REFRESH_HZ = 1000,
    parameter int unsigned ID_MS      = 500,
    parameter int unsigned DWELL_MS   = 2000,
    parameter int unsigned UPDATE_MS  = 250
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    disp_channel_scan_if.slave bus
);

    localparam int unsigned RDIV = CLK_HZ / REFRESH_HZ;
    localparam int unsigned MDIV = CLK_HZ / 1000;
    localparam int unsigned RW   = (RDIV > 1) ? $clog2(RDIV) : 1;
    localparam int unsigned MW   = (MDIV > 1) ? $clog2(MDIV) : 1;
    localparam int unsigned CW   = $clog2(DWELL_MS + 1);
    localparam int unsigned UW   = $clog2(UPDATE_MS + 1);
    localparam logic [3:0]  LAST_CH = 4'(N_CH - 1);

    logic [RW-1:0] rcnt_q;
    logic [MW-1:0] mcnt_q;
    logic          refresh_tick;
    logic          ms_tick;

    state_e        state_q;
    logic [3:0]    ch_idx_q;
    logic [CW-1:0] ms_cnt_q;
    logic [UW-1:0] upd_cnt_q;
    logic [15:0]   snap_q;
    logic [3:0]    ch_next;
    logic [15:0]   ch_word;

    logic [1:0]    dsel_q;
    logic [3:0]    an_q,  an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q,  dp_d;
    seg_mode_e     mode_d;
    logic [3:0]    nib_d;
    logic [3:0]    units;
    logic          tens_nz;

    assign refresh_tick = (rcnt_q == RW'(RDIV - 1));
    assign ms_tick      = (mcnt_q == MW'(MDIV - 1));
    assign ch_next      = (ch_idx_q == LAST_CH) ? '0 : ch_idx_q + 4'd1;
    assign ch_word      = bus.channels_bcd[16*ch_idx_q +: 16];

    // Free-running prescalers, each wrapping at DIV-1 with a one-cycle tick
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rcnt_q <= '0;
            mcnt_q <= '0;
        end else begin
            rcnt_q <= refresh_tick ? '0 : rcnt_q + 1'b1;
            mcnt_q <= ms_tick      ? '0 : mcnt_q + 1'b1;
        end
    end

    // Channel FSM: next_ch overrides everything; hold only freezes the dwell count in SHOW_VAL
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= SHOW_ID;
            ch_idx_q  <= '0;
            ms_cnt_q  <= '0;
            upd_cnt_q <= '0;
            snap_q    <= '0;
        end else if (bus.next_ch) begin
            state_q   <= SHOW_ID;
            ch_idx_q  <= ch_next;
            ms_cnt_q  <= '0;
            upd_cnt_q <= '0;
        end else if (ms_tick) begin
            unique case (state_q)
                SHOW_ID: begin
                    ms_cnt_q <= ms_cnt_q + 1'b1;
                    if (ms_cnt_q == CW'(ID_MS - 1)) begin
                        state_q   <= SHOW_VAL;
                        snap_q    <= ch_word;
                        upd_cnt_q <= '0;
                    end
                end
                SHOW_VAL: begin
                    if (!bus.hold && ms_cnt_q == CW'(DWELL_MS - 1)) begin
                        state_q  <= SHOW_ID;
                        ch_idx_q <= ch_next;
                        ms_cnt_q <= '0;
                    end else begin
                        if (!bus.hold) begin
                            ms_cnt_q <= ms_cnt_q + 1'b1;
                        end
                        // Snapshot refresh runs on its own counter so hold cannot stall it
                        if (upd_cnt_q == UW'(UPDATE_MS - 1)) begin
                            upd_cnt_q <= '0;
                            snap_q    <= ch_word;
                        end else begin
                            upd_cnt_q <= upd_cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= SHOW_ID;
            endcase
        end
    end

    assign tens_nz = (ch_idx_q >= 4'd10);
    assign units   = tens_nz ? ch_idx_q - 4'd10 : ch_idx_q;

    // Select what the digit addressed by dsel should show in the current frame
    always_comb begin
        mode_d = MODE_BLANK;
        nib_d  = '0;
        dp_d   = 1'b1;
        an_d   = ~(4'b0001 << dsel_q);
        if (state_q == SHOW_ID) begin
            unique case (dsel_q)
                2'd3: mode_d = MODE_C;
                2'd2: mode_d = MODE_BLANK;
                2'd1: begin
                    mode_d = tens_nz ? MODE_DIGIT : MODE_BLANK;
                    nib_d  = 4'd1;
                end
                default: begin
                    mode_d = MODE_DIGIT;
                    nib_d  = units;
                end
            endcase
        end else begin
            mode_d = MODE_DIGIT;
            nib_d  = snap_q[4*dsel_q +: 4];
            dp_d   = (dsel_q != 2'd3);
        end
    end

    seg7_decoder u_seg7_decoder (
        .mode_i   (mode_d),
        .nibble_i (nib_d),
        .seg_o    (seg_d)
    );

    // Pin registers load together from the current dsel, then dsel moves on
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dsel_q <= '0;
            an_q   <= 4'b1111;
            seg_q  <= SEG_BLANK;
            dp_q   <= 1'b1;
        end else if (refresh_tick) begin
            dsel_q <= dsel_q + 2'd1;
            an_q   <= an_d;
            seg_q  <= seg_d;
            dp_q   <= dp_d;
        end
    end

    assign bus.ch_idx = ch_idx_q;
    assign bus.an     = an_q;
    assign bus.seg    = seg_q;
    assign bus.dp     = dp_q;

endmodule
